// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file with scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 2;
  localparam int ZERO_IDX   = 0;

  // At least one address bit, even for a two-entry file.
  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read/write/reserve bus of the register file; master = issue/writeback side.
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF,
  parameter int AW     = addr_width(NREGS)
);
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic [NREGS-1:0]       busy_vec;
  logic [AW:0]            busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec, busy_cnt
  );
endinterface

// File: rtl/regfile_rd_port.sv
// One read port: stored value with write bypass, zero-register rule and
// a busy flag that is cleared by a same-cycle write, matching the bypass.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_width(NREGS)
) (
  input  logic [AW-1:0]          addr,
  input  logic [NREGS*XLEN-1:0]  regs_flat,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic [NREGS-1:0]       busy,
  output logic [XLEN-1:0]        v,
  output logic                   b
);

  logic            hit;
  logic [XLEN-1:0] byp;
  logic            is_zero;

  // Later ports overwrite earlier matches, so the highest index wins.
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
        hit = 1'b1;
        byp = wr_data[w*XLEN +: XLEN];
      end
    end
  end

  assign is_zero = (ZERO_REG != 0) && (addr == AW'(ZERO_IDX));

  always_comb begin
    v = regs_flat[int'(addr)*XLEN +: XLEN];
    if (is_zero) begin
      v = '0;
    end else if (hit) begin
      v = byp;
    end
  end

  assign b = busy[addr] & ~hit;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with bypass, busy scoreboard and an
// optional registered read stage.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = 1,
  parameter int REG_READ = 0,
  parameter int AW       = addr_width(NREGS)
) (
  input logic            clk,
  input logic            reset,
  regfile_mp_sb_if.slave bus
);

  logic [XLEN-1:0]        regs_reg  [NREGS];
  logic [XLEN-1:0]        regs_next [NREGS];
  logic [NREGS-1:0]       busy_reg;
  logic [NREGS-1:0]       busy_next;
  logic [NREGS*XLEN-1:0]  regs_flat;
  logic [NUM_RD*XLEN-1:0] v_flat;
  logic [NUM_RD-1:0]      b_flat;
  logic [AW:0]            cnt;

  // Writes apply in port order (highest index wins); a reservation is
  // applied after the write clears so a new producer keeps the bit set.
  always_comb begin
    regs_next = regs_reg;
    busy_next = busy_reg;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.wr_en[w]) begin
        regs_next[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*XLEN +: XLEN];
        busy_next[bus.wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (bus.rsv_en) begin
      busy_next[bus.rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_next[ZERO_IDX] = '0;
      busy_next[ZERO_IDX] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
      busy_reg <= '0;
    end else begin
      regs_reg <= regs_next;
      busy_reg <= busy_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_flat
      assign regs_flat[gi*XLEN +: XLEN] = regs_reg[gi];
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      regfile_rd_port #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .NUM_WR  (NUM_WR),
        .ZERO_REG(ZERO_REG),
        .AW      (AW)
      ) u_rd_port (
        .addr     (bus.rd_addr[gi*AW +: AW]),
        .regs_flat(regs_flat),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_data  (bus.wr_data),
        .busy     (busy_reg),
        .v        (v_flat[gi*XLEN +: XLEN]),
        .b        (b_flat[gi])
      );
    end

    if (REG_READ != 0) begin : g_rd_reg
      logic [NUM_RD*XLEN-1:0] rd_data_reg;
      logic [NUM_RD-1:0]      rd_busy_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data_reg <= '0;
          rd_busy_reg <= '0;
        end else begin
          rd_data_reg <= v_flat;
          rd_busy_reg <= b_flat;
        end
      end

      assign bus.rd_data = rd_data_reg;
      assign bus.rd_busy = rd_busy_reg;
    end else begin : g_rd_comb
      assign bus.rd_data = v_flat;
      assign bus.rd_busy = b_flat;
    end
  endgenerate

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + {{AW{1'b0}}, busy_reg[i]};
    end
  end

  assign bus.busy_vec = busy_reg;
  assign bus.busy_cnt = cnt;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Drives a combinational-read and a registered-read instance with identical
// stimulus and compares both against a register/scoreboard model.
module tb_regfile_mp_sb;

  logic clk;
  logic reset;

  regfile_mp_sb_if if_c ();
  regfile_mp_sb_if if_r ();

  regfile_mp_sb #(.REG_READ(0)) u_dut_c (.clk(clk), .reset(reset), .bus(if_c));
  regfile_mp_sb #(.REG_READ(1)) u_dut_r (.clk(clk), .reset(reset), .bus(if_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;

  // Model state: architectural registers and busy bits.
  logic [31:0] mregs [32];
  logic        mbusy [32];

  // Current cycle stimulus.
  logic        s_we   [2];
  int          s_wa   [2];
  logic [31:0] s_wd   [2];
  logic        s_rsv;
  int          s_ra;
  int          s_rd   [2];

  // Registered-read expectations (valid one cycle later).
  logic [31:0] exp_r_data [2];
  logic        exp_r_busy [2];
  logic        armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  function automatic void model_read(input int a, output logic [31:0] v, output logic b);
    logic hit;
    hit = 1'b0;
    v   = mregs[a];
    for (int w = 0; w < 2; w++) begin
      if (s_we[w] && s_wa[w] == a) begin
        hit = 1'b1;
        v   = s_wd[w];
      end
    end
    if (a == 0) v = 32'h0;
    b = mbusy[a] && !hit;
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] vec;
    for (int i = 0; i < 32; i++) vec[i] = mbusy[i];
    return vec;
  endfunction

  function automatic logic [31:0] model_cnt();
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) if (mbusy[i]) c++;
    return 32'(c);
  endfunction

  task automatic drive();
    for (int w = 0; w < 2; w++) begin
      if_c.wr_en[w]             = s_we[w];
      if_r.wr_en[w]             = s_we[w];
      if_c.wr_addr[w*5 +: 5]    = 5'(s_wa[w]);
      if_r.wr_addr[w*5 +: 5]    = 5'(s_wa[w]);
      if_c.wr_data[w*32 +: 32]  = s_wd[w];
      if_r.wr_data[w*32 +: 32]  = s_wd[w];
      if_c.rd_addr[w*5 +: 5]    = 5'(s_rd[w]);
      if_r.rd_addr[w*5 +: 5]    = 5'(s_rd[w]);
    end
    if_c.rsv_en   = s_rsv;
    if_r.rsv_en   = s_rsv;
    if_c.rsv_addr = 5'(s_ra);
    if_r.rsv_addr = 5'(s_ra);
  endtask

  task automatic cyc(input logic rst,
                     input logic we0, input int wa0, input logic [31:0] wd0,
                     input logic we1, input int wa1, input logic [31:0] wd1,
                     input logic rv, input int ra, input int a0, input int a1);
    logic [31:0] v;
    logic        b;
    logic [31:0] nxt_data [2];
    logic        nxt_busy [2];
    @(negedge clk);
    reset = rst;
    s_we[0] = we0; s_wa[0] = wa0; s_wd[0] = wd0;
    s_we[1] = we1; s_wa[1] = wa1; s_wd[1] = wd1;
    s_rsv = rv; s_ra = ra; s_rd[0] = a0; s_rd[1] = a1;
    drive();
    $display("cyc %0d rst=%0b w0=%0b x%0d=%h w1=%0b x%0d=%h rsv=%0b x%0d rd=x%0d,x%0d",
             n_cyc, rst, we0, wa0, wd0, we1, wa1, wd1, rv, ra, a0, a1);
    #1;
    for (int r = 0; r < 2; r++) begin
      model_read(s_rd[r], v, b);
      nxt_data[r] = v;
      nxt_busy[r] = b;
      if (armed) begin
        chk($sformatf("comb_data%0d", r), if_c.rd_data[r*32 +: 32], v);
        chk($sformatf("comb_busy%0d", r), 32'(if_c.rd_busy[r]), 32'(b));
        chk($sformatf("reg_data%0d", r), if_r.rd_data[r*32 +: 32], exp_r_data[r]);
        chk($sformatf("reg_busy%0d", r), 32'(if_r.rd_busy[r]), 32'(exp_r_busy[r]));
      end
    end
    if (armed) begin
      chk("comb_busy_vec", if_c.busy_vec, model_vec());
      chk("comb_busy_cnt", 32'(if_c.busy_cnt), model_cnt());
      chk("reg_busy_vec", if_r.busy_vec, model_vec());
      chk("reg_busy_cnt", 32'(if_r.busy_cnt), model_cnt());
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] = 32'h0;
        mbusy[i] = 1'b0;
      end
      for (int r = 0; r < 2; r++) begin
        exp_r_data[r] = 32'h0;
        exp_r_busy[r] = 1'b0;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (s_we[w] && s_wa[w] != 0) begin
          mregs[s_wa[w]] = s_wd[w];
          mbusy[s_wa[w]] = 1'b0;
        end
      end
      if (s_rsv && s_ra != 0) mbusy[s_ra] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        exp_r_data[r] = nxt_data[r];
        exp_r_busy[r] = nxt_busy[r];
      end
    end
    armed = 1'b1;
    n_cyc++;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    for (int w = 0; w < 2; w++) begin
      s_we[w] = 1'b0; s_wa[w] = 0; s_wd[w] = 32'h0; s_rd[w] = 0;
    end
    s_rsv = 1'b0; s_ra = 0;
    drive();

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 2*i, 2*i + 1);

    // Bypass then stored read of x5.
    cyc(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 5);
    chk("reg_bypass_x5", if_r.rd_data[63:32], 32'h1234);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    chk("reg_stored_x5", if_r.rd_data[31:0], 32'h1234);

    // Same-cycle conflict on x7: port 1 wins.
    cyc(0, 1, 7, 32'hAAAA, 1, 7, 32'h5555, 0, 0, 7, 7);
    chk("reg_conflict_x7", if_r.rd_data[31:0], 32'h5555);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("reg_stored_x7", if_r.rd_data[31:0], 32'h5555);

    // Zero register ignores writes and reservations.
    cyc(0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 0);
    chk("x0_busy", 32'(if_c.busy_vec[0]), 32'h0);
    chk("x0_cnt", 32'(if_c.busy_cnt), 32'h0);

    // Reserve x3, then write it; then reserve+write together.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    chk("rsv_x3_vec", 32'(if_c.busy_vec[3]), 32'h1);
    chk("rsv_x3_cnt", 32'(if_c.busy_cnt), 32'h1);
    cyc(0, 0, 0, 0, 1, 3, 32'h9, 0, 0, 3, 3);
    chk("wb_x3_data", if_r.rd_data[31:0], 32'h9);
    chk("wb_x3_busy", 32'(if_r.rd_busy[0]), 32'h0);
    chk("wb_x3_vec", 32'(if_c.busy_vec[3]), 32'h0);
    cyc(0, 1, 3, 32'h11, 0, 0, 0, 1, 3, 3, 0);
    chk("rsv_wins_x3", 32'(if_c.busy_vec[3]), 32'h1);

    // Reset with reservations pending.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 6);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, 4, 6);
    cyc(1, 1, 9, 32'hDEAD, 0, 0, 0, 1, 8, 4, 5);
    chk("rst_cnt", 32'(if_r.busy_cnt), 32'h0);
    chk("rst_rd_data", if_r.rd_data[63:32], 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 9);

    for (int k = 0; k < 500; k++) begin
      logic narrow;
      narrow = $urandom_range(0, 1) == 1;
      cyc(($urandom_range(0, 63) == 0),
          $urandom_range(0, 1) == 1, narrow ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom,
          $urandom_range(0, 1) == 1, narrow ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom,
          $urandom_range(0, 2) == 0, narrow ? $urandom_range(0, 7) : $urandom_range(0, 31),
          narrow ? $urandom_range(0, 7) : $urandom_range(0, 31),
          narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
